// File: rtl/dmux_stream_sequencer.sv
// Valid/ready front-end for a fixed-latency pipelined demux: holds sel/in stable
// for LATENCY cycles, then captures the selected lane and strobes it downstream.
module dmux_stream_sequencer #(
  parameter int WIDTH        = 1,
  parameter int OUTPUT_COUNT = 2,
  parameter int LATENCY      = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [$clog2(OUTPUT_COUNT):0]      s_sel,
  input  logic [WIDTH-1:0]                   s_data,
  output logic [$clog2(OUTPUT_COUNT):0]      dmux_sel,
  output logic [WIDTH-1:0]                   dmux_in,
  input  logic [WIDTH*OUTPUT_COUNT-1:0]      dmux_out,
  output logic [OUTPUT_COUNT-1:0]            m_strobe,
  output logic [WIDTH*OUTPUT_COUNT-1:0]      m_data,
  output logic                               err
);

  localparam int SW = $clog2(OUTPUT_COUNT) + 1;
  localparam int CW = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1);
  localparam logic [SW-1:0] LANES = SW'(OUTPUT_COUNT);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                          r_state, w_state_nxt;
  logic [CW-1:0]                   r_cnt;
  logic [SW-1:0]                   r_dmux_sel;
  logic [WIDTH-1:0]                r_dmux_in;
  logic [OUTPUT_COUNT-1:0]         r_m_strobe;
  logic [WIDTH*OUTPUT_COUNT-1:0]   r_m_data;
  logic                            r_err;

  logic w_accept, w_in_range, w_load, w_drop, w_capture;

  assign s_ready    = (r_state == IDLE) && rst_n;
  assign w_accept   = s_valid && s_ready;
  assign w_in_range = (s_sel < LANES);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_in_range) begin
            w_load      = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dmux_sel <= '0;
      r_dmux_in  <= '0;
      r_m_strobe <= '0;
      r_m_data   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_drop;
      if (w_load) begin
        r_dmux_sel <= s_sel;
        r_dmux_in  <= s_data;
        r_cnt      <= CW'(LATENCY);
      end else if (r_state == HOLD && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      // Lane decode by loop keeps the capture mux free of a variable multiply.
      for (int unsigned k = 0; k < OUTPUT_COUNT; k++) begin
        r_m_strobe[k] <= w_capture && (r_dmux_sel == SW'(k));
        if (w_capture && (r_dmux_sel == SW'(k)))
          r_m_data[k*WIDTH +: WIDTH] <= dmux_out[k*WIDTH +: WIDTH];
      end
    end
  end

  assign dmux_sel = r_dmux_sel;
  assign dmux_in  = r_dmux_in;
  assign m_strobe = r_m_strobe;
  assign m_data   = r_m_data;
  assign err      = r_err;

endmodule
